// File: rtl/config_pkg.sv
// Shared engine configuration: vector length, element format and ternary encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package config_pkg;

    // Vector length and square matrix dimension of the ternary engine.
    localparam int D      = 4;
    // Element width; vector elements are signed fixed-point words.
    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef elem_t [D-1:0] vector_t;

    // Ternary weight encoding: 2'b01 = +1, 2'b11 = -1, anything else = 0.
    typedef logic [1:0] trit_t;
    typedef trit_t [D-1:0] trit_row_t;
    // Index as matrix[row][col]; result[row] = sum over col of matrix[row][col] * vector[col].
    typedef trit_row_t [D-1:0] ternary_matrix_t;

endpackage

// File: rtl/ternary_matmul_arbiter.sv
// Round-robin arbiter and job sequencer sharing one ternary_matmul engine among N_REQ requesters.
// Latency: accept in cycle t, engine issue t+1, engine result t+2+D, rsp_valid_o from t+3+D.
// Backpressure: one job in flight; the response is held until its owner takes it, and no new job is accepted meanwhile.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   req_vector_i/req_matrix_i        per-requester operands, sampled only on accept
//   req_valid_i / req_ready_o        per-requester job handshake (ready is one-hot, combinational)
//   rsp_vector_o                     result, broadcast to all requesters
//   rsp_valid_o / rsp_ready_i        per-requester result handshake (valid is one-hot to the owner)
//   mm_vector_o/mm_matrix_o          engine operands, held stable for the whole job
//   mm_valid_o / mm_ready_i          engine input handshake
//   mm_vector_i, mm_valid_i/mm_ready_o engine output handshake
//   busy_o                           high whenever a job is in flight
//   owner_o                          index of the current or most recent job owner
module ternary_matmul_arbiter
    import config_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  vector_t         [N_REQ-1:0] req_vector_i,
    input  ternary_matrix_t [N_REQ-1:0] req_matrix_i,
    input  logic            [N_REQ-1:0] req_valid_i,
    output logic            [N_REQ-1:0] req_ready_o,

    output vector_t                     rsp_vector_o,
    output logic            [N_REQ-1:0] rsp_valid_o,
    input  logic            [N_REQ-1:0] rsp_ready_i,

    output vector_t                     mm_vector_o,
    output ternary_matrix_t             mm_matrix_o,
    output logic                        mm_valid_o,
    input  logic                        mm_ready_i,
    input  vector_t                     mm_vector_i,
    input  logic                        mm_valid_i,
    output logic                        mm_ready_o,

    output logic                        busy_o,
    output logic            [IDW-1:0]   owner_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_COMPUTE,
        ST_RESPOND
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_q,  last_d;
    logic [IDW-1:0]  owner_q, owner_d;
    vector_t         op_vec_q, op_vec_d;
    ternary_matrix_t op_mat_q, op_mat_d;
    vector_t         res_q,   res_d;

    logic [IDW-1:0]  sel;
    logic [IDW-1:0]  cand;
    logic            sel_vld;
    logic            accept;

    // Rotating priority search: start one past the last grant and wrap, so a
    // requester that keeps asking is served within N_REQ jobs.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_q) + k) % N_REQ);
            if (!sel_vld && req_valid_i[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
        end
    end

    assign accept      = (state_q == ST_IDLE) && sel_vld;
    assign req_ready_o = accept ? (N_REQ'(1) << sel) : '0;

    // Next-state and register updates. Operands only move on an accept so the
    // engine sees constant inputs while it iterates over them.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        op_vec_d = op_vec_q;
        op_mat_d = op_mat_q;
        res_d    = res_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    op_vec_d = req_vector_i[sel];
                    op_mat_d = req_matrix_i[sel];
                    owner_d  = sel;
                    last_d   = sel;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mm_ready_i) begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (mm_valid_i) begin
                    res_d   = mm_vector_i;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                // Only the owner's accept counts; other rsp_ready_i bits are don't-care.
                if (rsp_ready_i[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            // Start just below 0 so requester 0 wins the first arbitration.
            last_q   <= IDW'(N_REQ - 1);
            owner_q  <= '0;
            op_vec_q <= '0;
            op_mat_q <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            op_vec_q <= op_vec_d;
            op_mat_q <= op_mat_d;
            res_q    <= res_d;
        end
    end

    // Everything below is decoded from registers only, so no combinational
    // path runs from the engine or the requesters to these outputs.
    assign mm_vector_o  = op_vec_q;
    assign mm_matrix_o  = op_mat_q;
    assign mm_valid_o   = (state_q == ST_ISSUE);
    assign mm_ready_o   = (state_q == ST_COMPUTE);
    assign rsp_vector_o = res_q;
    assign rsp_valid_o  = (state_q == ST_RESPOND) ? (N_REQ'(1) << owner_q) : '0;
    assign busy_o       = (state_q != ST_IDLE);
    assign owner_o      = owner_q;

endmodule

// File: doc/ternary_matmul_arbiter.md
# ternary_matmul_arbiter

Round-robin arbiter and job sequencer that shares one `ternary_matmul` engine between `N_REQ` independent requesters. It accepts one job (vector + ternary matrix) at a time and latches the operands into local registers. It then drives the engine through its input handshake, holds the operands stable for the whole computation, and captures the engine result. The result is returned only to the requester that owns the job. The block sits between the requester ports (layer controllers) and the single engine instance.

## Interface
- `N_REQ`, default 4: number of requesters, ≥ 2. `IDW = $clog2(N_REQ)`.
- `D`, `vector_t`, `ternary_matrix_t`: taken from `config_pkg`, not redefined here.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_ni`, in, 1: reset, asynchronous and active-low.
- `req_vector_i`, in, `N_REQ` × `vector_t`: per-requester input vector.
- `req_matrix_i`, in, `N_REQ` × `ternary_matrix_t`: per-requester matrix.
- `req_valid_i`, in, `N_REQ`: job request.
- `req_ready_o`, out, `N_REQ`: job accepted; at most one bit high (one-hot).
- `rsp_vector_o`, out, `vector_t`: result, broadcast to all requesters.
- `rsp_valid_o`, out, `N_REQ`: result valid for the owner only (one-hot).
- `rsp_ready_i`, in, `N_REQ`: per-requester result accept.
- `mm_vector_o`, out, `vector_t`: engine input vector, from the operand register.
- `mm_matrix_o`, out, `ternary_matrix_t`: engine input matrix, from the operand register.
- `mm_valid_o`, out, 1: engine input valid.
- `mm_ready_i`, in, 1: engine `in_ready_o`.
- `mm_vector_i`, in, `vector_t`: engine result.
- `mm_valid_i`, in, 1: engine `out_valid_o`.
- `mm_ready_o`, out, 1: drives engine `out_ready_i`.
- `busy_o`, out, 1: high in every state except IDLE.
- `owner_o`, out, `IDW`: index of the current or most recent job owner.

## Operation
States: IDLE, ISSUE, COMPUTE, RESPOND.

- **IDLE**
  - `sel` is the first index with `req_valid_i` set, searching from `last+1` mod `N_REQ` and wrapping.
  - If any request is valid, `req_ready_o[sel]` = 1 combinationally.
  - On that cycle, latch `req_vector_i[sel]` and `req_matrix_i[sel]` into the operand registers, set `owner` = `sel` and `last` = `sel`, then go to ISSUE.
  - If no request is valid, stay in IDLE and leave `last` unchanged.
- **ISSUE**
  - `mm_valid_o` = 1.
  - On `mm_ready_i`, go to COMPUTE.
  - `mm_valid_o` must stay high until the handshake completes.
- **COMPUTE**
  - `mm_ready_o` = 1.
  - On `mm_valid_i`, capture `mm_vector_i` into the result register and go to RESPOND.
- **RESPOND**
  - `rsp_valid_o[owner]` = 1 and `rsp_vector_o` = result register.
  - On `rsp_ready_i[owner]`, go to IDLE.
  - `rsp_ready_i` bits of non-owners are ignored.

Rules that hold in all states:
- Operand registers change only on an IDLE accept. They stay stable through ISSUE and COMPUTE, because the engine reads `mm_vector_o` and `mm_matrix_o` every cycle while working.
- `mm_valid_i` outside COMPUTE is ignored and `mm_ready_o` stays 0.
- No arithmetic is done in this block. Data is passed bit-exact.
- Fairness: a continuously asserted request is granted within `N_REQ` jobs.
- A requester may drop `req_valid_i` before it is granted; nothing is latched for it.

## Timing
Reset (asynchronous, active-low) puts the block in this state:
- state = IDLE, `last` = `N_REQ`-1 (so requester 0 wins first), `owner` = 0.
- Operand and result registers = 0.
- All `*_valid_o` and `*_ready_o` outputs = 0, `busy_o` = 0, `owner_o` = 0.

Reset and latency rules:
- Reset mid-job abandons the job; no response is ever produced for it.
- The engine shares `rst_ni` and returns to its idle state.
- Latency with the engine idle and the owner ready, counting the accept in cycle t:
  - ISSUE handshake in cycle t+1.
  - Engine works for cycles t+2 through t+1+D.
  - `mm_valid_i` in cycle t+2+D.
  - `rsp_valid_o` in cycle t+3+D.
- Throughput: one job per D+4 cycles. The next accept is no earlier than the cycle after the response handshake.
- The response is held indefinitely under backpressure, and new requests wait in the meantime.
- `req_ready_o` is combinational from `req_valid_i` and state. All other outputs are registered or decoded from state only.

## Test plan
Test configuration: D = 4, `N_REQ` = 4. Vector values below are in `config_pkg` fixed-point units.

- Single job: requester 2 sends v = [1,2,3,4] with the identity matrix. `req_ready_o` = 0100 in cycle t, `rsp_valid_o` = 0100 in cycle t+7, and `rsp_vector_o` = [1,2,3,4].
- Ternary mix: row 0 = all −1, row 1 = [1,0,−1,0], rows 2–3 = 0, v = [1,2,3,4]. Result = [−10,−2,0,0].
- Round robin: all four requesters hold valid from reset. Grants occur in order 0,1,2,3,0, with each result routed only to its owner.
- Operand hold: requester 0 changes `req_vector_i` and `req_matrix_i` every cycle after its accept. The result must reflect only the values latched at accept.
- Backpressure: the owner holds `rsp_ready_i` = 0 for 20 cycles while the others request. `rsp_valid_o` and `rsp_vector_o` stay stable, no other `req_ready_o` is asserted, and the next grant follows the response handshake.
- Reset mid-COMPUTE: assert `rst_ni` = 0 asynchronously. All outputs reach reset values immediately, no response is produced after release, and a new job completes correctly.
